// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment table for the seg_scan_mux display driver.
package seg_pkg;

  // Segment bit positions inside the 8-bit pattern: bits[6:0] = g..a, bit 7 = decimal point.
  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high "everything off" pattern (inverted later for common-anode boards).
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high g..a pattern for one hex nibble.
  function automatic logic [6:0] seg_hex(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point -> active-high 8-bit segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  // Assemble g..a from the table and drop the decimal point into bit 7.
  always_comb begin
    seg_o              = SEG_OFF;
    seg_o[SEG_G:SEG_A] = seg_hex(nibble_i);
    seg_o[SEG_DP]      = dp_i;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scan driver: DIGITS hex digits time-shared on one segment
// bus with one-hot digit selects, a blank window at the start of every slot, and a
// per-frame snapshot of the inputs announced by frame_start.
// Optional build macro SEG_LEAD_ZERO_BLANK_EN: suppress leading zero digits at
// snapshot time (digit 0 always shows; a suppressed digit still lights its dp).
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [7:0]            seg_data,
  output logic [DIGITS-1:0]     seg_cs,
  output logic                  frame_start
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Idle levels at the pins; XOR with these turns active-high into board polarity.
  localparam logic [DIGITS-1:0] CS_IDLE  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]        SEG_IDLE = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  snap_data_q, snap_data_d;
  logic [DIGITS-1:0]       snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]       snap_en_q, snap_en_d;
  logic [DIGITS-1:0]       snap_sup_q, snap_sup_d;
  logic                    frame_start_q, frame_start_d;
  logic [7:0]              seg_data_q, seg_data_d;
  logic [DIGITS-1:0]       seg_cs_q, seg_cs_d;

  logic [DIGITS-1:0][3:0]  data_nib;
  logic                    load;
  logic [7:0]              dec_pattern;
  logic [DIGITS-1:0]       cs_hi;
  logic [7:0]              seg_hi;

  assign data_nib = data;
  assign load     = (cnt_q == '0) && (idx_q == '0);

  // Slot counter and digit index: idx steps on the last clock of each slot.
  // NOTE: combinational blocks assign every output a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) idx_d = '0;
      else                             idx_d = idx_q + IDX_W'(1);
    end
  end

`ifdef SEG_LEAD_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_keep;

  // Keep every digit at or below the highest nonzero nibble; digit 0 always kept.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lz_keep = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen       = seen | (data_nib[i] != 4'h0);
      lz_keep[i] = seen;
    end
    lz_keep[0] = 1'b1;
  end
`endif

  // Frame snapshot: capture inputs on the first clock of slot 0, which is blank.
  always_comb begin
    snap_data_d   = snap_data_q;
    snap_dp_d     = snap_dp_q;
    snap_en_d     = snap_en_q;
    snap_sup_d    = snap_sup_q;
    frame_start_d = load;
    if (load) begin
      snap_data_d = data_nib;
      snap_dp_d   = dp;
`ifdef SEG_LEAD_ZERO_BLANK_EN
      // A suppressed digit stays selectable only to show its decimal point.
      snap_en_d   = digit_en & (lz_keep | dp);
      snap_sup_d  = ~lz_keep;
`else
      snap_en_d   = digit_en;
      snap_sup_d  = '0;
`endif
    end
  end

  seg_hex_decode u_dec (
    .nibble_i (snap_data_q[idx_q]),
    .dp_i     (snap_dp_q[idx_q]),
    .seg_o    (dec_pattern)
  );

  // Next output pattern from the current slot position and the frame snapshot.
  always_comb begin
    cs_hi  = '0;
    seg_hi = SEG_OFF;
    if ((cnt_q >= CNT_W'(BLANK_CYC)) && snap_en_q[idx_q]) begin
      cs_hi  = DIGITS'(1) << idx_q;
      seg_hi = dec_pattern;
      if (snap_sup_q[idx_q]) begin
        seg_hi         = SEG_OFF;
        seg_hi[SEG_DP] = snap_dp_q[idx_q];
      end
    end
    seg_cs_d   = cs_hi ^ CS_IDLE;
    seg_data_d = seg_hi ^ SEG_IDLE;
  end

  // State and output registers; reset aborts the scan and drives the pins idle.
  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is cleared on
      // reset to give a defined state before the first capture.
      snap_data_q   <= '0;
      snap_dp_q     <= '0;
      snap_en_q     <= '0;
      snap_sup_q    <= '0;
      frame_start_q <= 1'b0;
      seg_data_q    <= SEG_IDLE;
      seg_cs_q      <= CS_IDLE;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_data_q   <= snap_data_d;
      snap_dp_q     <= snap_dp_d;
      snap_en_q     <= snap_en_d;
      snap_sup_q    <= snap_sup_d;
      frame_start_q <= frame_start_d;
      seg_data_q    <= seg_data_d;
      seg_cs_q      <= seg_cs_d;
    end
  end

  assign seg_data    = seg_data_q;
  assign seg_cs      = seg_cs_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: DIGITS=4, DIV=10, BLANK_CYC=2, with an
// active-high and an active-low instance sharing all inputs.
module tb_seg_scan_mux;

  localparam int DIGITS    = 4;
  localparam int CLK_HZ    = 1000;
  localparam int SCAN_HZ   = 100;
  localparam int BLANK_CYC = 2;
  localparam int DIV       = CLK_HZ / SCAN_HZ;
  localparam int FRAME     = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = '0;

  logic [7:0]  seg_data, seg_data_al;
  logic [3:0]  seg_cs, seg_cs_al;
  logic        frame_start, frame_start_al;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ),
                 .BLANK_CYC(BLANK_CYC), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .digit_en(digit_en),
    .seg_data(seg_data), .seg_cs(seg_cs), .frame_start(frame_start)
  );

  seg_scan_mux #(.DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ),
                 .BLANK_CYC(BLANK_CYC), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .digit_en(digit_en),
    .seg_data(seg_data_al), .seg_cs(seg_cs_al), .frame_start(frame_start_al)
  );

  // ---------------- reference model ----------------
  // Time-based view: the pins after the n-th clock out of reset show scan
  // position n-1; a frame's inputs are those present at the first clock of it.
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          n = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0, m_en = '0;
  logic [3:0]  exp_cs = '0;
  logic [7:0]  exp_seg = '0;
  logic        exp_fs = 1'b0;

  function automatic void model_out(input int pos, output logic [3:0] cs, output logic [7:0] seg);
    int   phase = pos % DIV;
    int   dig   = (pos / DIV) % DIGITS;
    int   top   = 0;
    bit   shown = 1'b1;
    logic [3:0] nib;
    cs  = '0;
    seg = '0;
    for (int i = 0; i < DIGITS; i++) if (m_data[4*i +: 4] != 4'h0) top = i;
`ifdef SEG_LEAD_ZERO_BLANK_EN
    shown = (dig <= top);
`endif
    nib = m_data[4*dig +: 4];
    if (phase >= BLANK_CYC && m_en[dig]) begin
      if (shown) begin
        cs  = 4'(1 << dig);
        seg = {m_dp[dig], hex_tab[nib]};
      end else if (m_dp[dig]) begin
        cs  = 4'(1 << dig);
        seg = 8'h80;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      n = 0; exp_cs = '0; exp_seg = '0; exp_fs = 1'b0;
    end else begin
      if (n % FRAME == 0) begin
        m_data = data; m_dp = dp; m_en = digit_en;
      end
      exp_fs = (n % FRAME == 0);
      model_out(n, exp_cs, exp_seg);
      n++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst = 1'b1;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    data = 16'h1234; dp = '0; digit_en = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (seg_cs !== 4'h0 || seg_data !== 8'h00 || frame_start !== 1'b0) begin
        failures++;
        $display("FAIL reset_hi cs=%b seg=%h fs=%b expected cs=0000 seg=00 fs=0", seg_cs, seg_data, frame_start);
      end
      checks++;
      if (seg_cs_al !== 4'hF || seg_data_al !== 8'hFF || frame_start_al !== 1'b0) begin
        failures++;
        $display("FAIL reset_lo cs=%b seg=%h fs=%b expected cs=1111 seg=ff fs=0", seg_cs_al, seg_data_al, frame_start_al);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 2 * FRAME + 1; k++) begin
      @(negedge clk);
      checks++;
      if (frame_start !== ((k - 1) % FRAME == 0) || frame_start_al !== frame_start) begin
        failures++;
        $display("FAIL frame_start k=%0d got %b/%b expected %b", k, frame_start, frame_start_al, ((k - 1) % FRAME == 0));
      end
      checks++;
      if (seg_cs !== exp_cs || seg_data !== exp_seg) begin
        failures++;
        $display("FAIL reset_scan k=%0d cs=%b seg=%h expected cs=%b seg=%h", k, seg_cs, seg_data, exp_cs, exp_seg);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [7:0] seq [4];
    seq = '{8'h66, 8'h4F, 8'h5B, 8'h06};
    data = 16'h1234; dp = '0; digit_en = 4'hF;
    do_reset(3);
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      if (k % DIV == 1 || k % DIV == 2) begin
        checks++;
        if (seg_cs !== 4'h0 || seg_data !== 8'h00) begin
          failures++;
          $display("FAIL scan_blank k=%0d cs=%b seg=%h expected cs=0000 seg=00", k, seg_cs, seg_data);
        end
      end
      if (k % DIV == 5) begin
        checks++;
        if (seg_cs !== 4'(1 << ((k / DIV) % 4)) || seg_data !== seq[(k / DIV) % 4]) begin
          failures++;
          $display("FAIL scan_lit k=%0d cs=%b seg=%h expected seg=%h", k, seg_cs, seg_data, seq[(k / DIV) % 4]);
        end
      end
    end
  endtask

  task automatic test_mid_frame();
    logic [7:0] seq [8];
    seq = '{8'h66, 8'h4F, 8'h5B, 8'h06, 8'h5E, 8'h39, 8'h7C, 8'h77};
    data = 16'h1234; dp = '0; digit_en = 4'hF;
    do_reset(3);
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      if (k % DIV == 5) begin
        checks++;
        if (seg_cs !== 4'(1 << ((k / DIV) % 4)) || seg_data !== seq[k / DIV]) begin
          failures++;
          $display("FAIL mid_frame slot=%0d cs=%b seg=%h expected seg=%h", k / DIV, seg_cs, seg_data, seq[k / DIV]);
        end
      end
      if (k == 25) data = 16'hABCD;
    end
  endtask

  task automatic test_en_dp();
    logic [7:0] lit_seg [4];
    logic [3:0] lit_cs  [4];
    lit_seg = '{8'h3F, 8'h00, 8'hFF, 8'h00};
    lit_cs  = '{4'b0001, 4'b0000, 4'b0100, 4'b0000};
    data = 16'h0880; dp = 4'b0100; digit_en = 4'b0101;
    do_reset(3);
    for (int k = 1; k <= FRAME; k++) begin
      int pos, dig;
      logic [3:0] ecs;
      logic [7:0] eseg;
      @(negedge clk);
      pos  = k - 1;
      dig  = pos / DIV;
      ecs  = (pos % DIV >= BLANK_CYC) ? lit_cs[dig]  : 4'h0;
      eseg = (pos % DIV >= BLANK_CYC) ? lit_seg[dig] : 8'h00;
      checks++;
      if (seg_cs !== ecs || seg_data !== eseg) begin
        failures++;
        $display("FAIL en_dp k=%0d cs=%b seg=%h expected cs=%b seg=%h", k, seg_cs, seg_data, ecs, eseg);
      end
    end
  endtask

  task automatic test_active_low_reset();
    data = 16'h1234; dp = '0; digit_en = 4'hF;
    do_reset(3);
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (seg_cs_al !== 4'hF || seg_data_al !== 8'hFF || frame_start_al !== 1'b0) begin
      failures++;
      $display("FAIL al_midreset cs=%b seg=%h fs=%b expected cs=1111 seg=ff fs=0", seg_cs_al, seg_data_al, frame_start_al);
    end
    checks++;
    if (seg_cs !== 4'h0 || seg_data !== 8'h00) begin
      failures++;
      $display("FAIL ah_midreset cs=%b seg=%h expected cs=0000 seg=00", seg_cs, seg_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start_al !== 1'b1 || seg_cs_al !== 4'hF) begin
      failures++;
      $display("FAIL al_restart fs=%b cs=%b expected fs=1 cs=1111", frame_start_al, seg_cs_al);
    end
    @(negedge clk);
    checks++;
    if (frame_start_al !== 1'b0 || seg_cs_al !== 4'hF || seg_data_al !== 8'hFF) begin
      failures++;
      $display("FAIL al_blank fs=%b cs=%b seg=%h expected fs=0 cs=1111 seg=ff", frame_start_al, seg_cs_al, seg_data_al);
    end
    @(negedge clk);
    checks++;
    if (seg_cs_al !== 4'b1110 || seg_data_al !== 8'h99) begin
      failures++;
      $display("FAIL al_lit cs=%b seg=%h expected cs=1110 seg=99", seg_cs_al, seg_data_al);
    end
  endtask

  task automatic test_lead_zero();
    for (int p = 0; p < 2; p++) begin
      logic [7:0] lit0;
      data = (p == 0) ? 16'h0007 : 16'h0000;
      lit0 = (p == 0) ? 8'h07 : 8'h3F;
      dp = '0; digit_en = 4'hF;
      do_reset(3);
      for (int k = 1; k <= FRAME; k++) begin
        int s;
        logic [3:0] ecs;
        logic [7:0] eseg;
        @(negedge clk);
        if (k % DIV == 5) begin
          s = k / DIV;
`ifdef SEG_LEAD_ZERO_BLANK_EN
          ecs  = (s == 0) ? 4'b0001 : 4'b0000;
          eseg = (s == 0) ? lit0 : 8'h00;
`else
          ecs  = 4'(1 << s);
          eseg = (s == 0) ? lit0 : 8'h3F;
`endif
          checks++;
          if (seg_cs !== ecs || seg_data !== eseg) begin
            failures++;
            $display("FAIL lead_zero data=%h slot=%0d cs=%b seg=%h expected cs=%b seg=%h", data, s, seg_cs, seg_data, ecs, eseg);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset(2);
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      checks++;
      if (seg_cs !== exp_cs || seg_data !== exp_seg || frame_start !== exp_fs) begin
        failures++;
        $display("FAIL rand_hi k=%0d cs=%b seg=%h fs=%b expected cs=%b seg=%h fs=%b", k, seg_cs, seg_data, frame_start, exp_cs, exp_seg, exp_fs);
      end
      checks++;
      if (seg_cs_al !== ~exp_cs || seg_data_al !== ~exp_seg || frame_start_al !== exp_fs) begin
        failures++;
        $display("FAIL rand_lo k=%0d cs=%b seg=%h fs=%b expected cs=%b seg=%h fs=%b", k, seg_cs_al, seg_data_al, frame_start_al, ~exp_cs, ~exp_seg, exp_fs);
      end
      if ($urandom_range(24) == 0) begin
        for (int i = 0; i < DIGITS; i++)
          data[4*i +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
        dp       = 4'($urandom);
        digit_en = 4'($urandom);
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(149) == 0) rst = 1'b1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_mid_frame();
    test_en_dp();
    test_active_low_reset();
    test_lead_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
